// File: rtl/ysyx_22050854_operand_read.sv
// Operand read stage: holds one decoded instruction, fetches rs1/rs2 from the
// register file (or bypasses the same-cycle write-back), and hands operands to
// execute over valid/ready. A per-register pending-writer scoreboard blocks
// RAW hazards and limits outstanding writers per register.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   flush                       drop the held instruction
//   in_*                        decoded instruction (valid/ready handshake)
//   rf_raddra/b, rf_rdata1/2    register file read ports (combinational data)
//   wb_wen, wb_rd, wb_data      write-back port, same cycle as the RF write
//   out_*                       operands + rd to execute (valid/ready handshake)
module ysyx_22050854_operand_read #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic            in_rs1_en,
    input  logic            in_rs2_en,
    input  logic [4:0]      in_rd,
    input  logic            in_rd_wen,
    output logic [4:0]      rf_raddra,
    output logic [4:0]      rf_raddrb,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    input  logic            wb_wen,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_src1,
    output logic [XLEN-1:0] out_src2,
    output logic [4:0]      out_rd,
    output logic            out_rd_wen
);

    localparam logic [CNT_W-1:0] PEND_MAX = '1;
    localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

    typedef enum logic [1:0] {EMPTY, WAIT, FULL} state_t;

    state_t           state;
    logic [4:0]       h_rs1, h_rs2, h_rd;
    logic             h_rs1_en, h_rs2_en, h_rd_wen;
    logic             got1, got2;
    logic [CNT_W-1:0] pend [32];

    logic            accept, out_fire, ok1, ok2, cap_stall;
    logic [XLEN-1:0] val1, val2;
    logic [31:0]     inc_v, dec_v;

    assign in_ready  = rst_n && !flush && (state == EMPTY || (state == FULL && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign rf_raddra = h_rs1;
    assign rf_raddrb = h_rs2;
    assign out_rd    = h_rd;
    assign out_rd_wen = h_rd_wen;

    // Operand resolution: zero for unused/x0, RF when no writer is pending,
    // bypass when the last pending writer retires this very cycle.
    always_comb begin
        ok1 = 1'b0;
        val1 = '0;
        if (!h_rs1_en || h_rs1 == 5'd0) begin
            ok1 = 1'b1;
        end else if (pend[h_rs1] == '0) begin
            ok1 = 1'b1;
            val1 = rf_rdata1;
        end else if (pend[h_rs1] == PEND_ONE && wb_wen && wb_rd == h_rs1) begin
            ok1 = 1'b1;
            val1 = wb_data;
        end
        ok2 = 1'b0;
        val2 = '0;
        if (!h_rs2_en || h_rs2 == 5'd0) begin
            ok2 = 1'b1;
        end else if (pend[h_rs2] == '0) begin
            ok2 = 1'b1;
            val2 = rf_rdata2;
        end else if (pend[h_rs2] == PEND_ONE && wb_wen && wb_rd == h_rs2) begin
            ok2 = 1'b1;
            val2 = wb_data;
        end
    end

    // Counter saturated: one more writer to rd cannot be tracked yet.
    assign cap_stall = h_rd_wen && h_rd != 5'd0 && pend[h_rd] == PEND_MAX;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_src1  <= '0;
            out_src2  <= '0;
            got1      <= 1'b0;
            got2      <= 1'b0;
            h_rs1     <= '0;
            h_rs2     <= '0;
            h_rs1_en  <= 1'b0;
            h_rs2_en  <= 1'b0;
            h_rd      <= '0;
            h_rd_wen  <= 1'b0;
        end else if (flush) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            got1      <= 1'b0;
            got2      <= 1'b0;
        end else begin
            case (state)
                EMPTY: if (accept) state <= WAIT;
                WAIT: begin
                    if (!got1 && ok1) begin
                        out_src1 <= val1;
                        got1     <= 1'b1;
                    end
                    if (!got2 && ok2) begin
                        out_src2 <= val2;
                        got2     <= 1'b1;
                    end
                    if ((got1 || ok1) && (got2 || ok2) && !cap_stall) begin
                        state     <= FULL;
                        out_valid <= 1'b1;
                    end
                end
                FULL: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= accept ? WAIT : EMPTY;
                end
                default: state <= EMPTY;
            endcase
            // accept is only possible in EMPTY or FULL, never races the WAIT captures
            if (accept) begin
                h_rs1    <= in_rs1;
                h_rs2    <= in_rs2;
                h_rs1_en <= in_rs1_en;
                h_rs2_en <= in_rs2_en;
                h_rd     <= in_rd;
                h_rd_wen <= in_rd_wen;
                got1     <= 1'b0;
                got2     <= 1'b0;
            end
        end
    end

    // Scoreboard events; a handoff squashed by flush is not counted.
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            inc_v[r] = (r != 0) && out_fire && !flush && out_rd_wen && out_rd == 5'(r);
            dec_v[r] = (r != 0) && wb_wen && wb_rd == 5'(r) && pend[r] != '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) pend[r] <= '0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (inc_v[r] && !dec_v[r])      pend[r] <= pend[r] + PEND_ONE;
                else if (dec_v[r] && !inc_v[r]) pend[r] <= pend[r] - PEND_ONE;
            end
        end
    end

endmodule

// File: doc/ysyx_22050854_operand_read.md
# ysyx_22050854_operand_read

Register read / operand fetch stage: the read-side counterpart of write-back. It accepts one decoded instruction at a time and reads `rs1`/`rs2` from the register file's read ports. It tracks in-flight destination registers in a per-register pending-write scoreboard, stalls on RAW hazards, and bypasses the same-cycle write-back data. It delivers operands to execute over a valid/ready handshake.

## Interface
- `XLEN`, 64: operand/data width.
- `CNT_W`, 2: pending-counter width per register; maximum outstanding writers per register is 2^CNT_W−1.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  discard the held instruction.
- `in_valid`  in  1  decoded instruction present.
- `in_ready`  out  1  stage can accept.
- `in_rs1`, `in_rs2`  in  5  source register indices.
- `in_rs1_en`, `in_rs2_en`  in  1  source used.
- `in_rd`  in  5  destination index.
- `in_rd_wen`  in  1  instruction writes `rd`.
- `rf_raddra`, `rf_raddrb`  out  5  register file read addresses.
- `rf_rdata1`, `rf_rdata2`  in  XLEN  register file combinational read data.
- `wb_wen`  in  1  write-back writing this cycle; the same signal as the register file `wen`.
- `wb_rd`  in  5  write-back destination.
- `wb_data`  in  XLEN  write-back data, as selected for the register file.
- `out_valid`  out  1  operands ready for execute.
- `out_ready`  in  1  execute accepts.
- `out_src1`, `out_src2`  out  XLEN  operands.
- `out_rd`  out  5  destination, passed through.
- `out_rd_wen`  out  1  write enable, passed through.

## Operation
- FSM states:
  - EMPTY: nothing held.
  - WAIT: instruction held, operands not yet captured.
  - FULL: operands captured, `out_valid`=1.
- `in_ready` = rst_n && !flush && (EMPTY || (FULL && out_ready)).
- Accept (`in_valid && in_ready`):
  - Load the hold register (rs1, rs2, enables, rd, rd_wen).
  - Clear the captured flags `got1`/`got2`.
  - Go to WAIT.
- `rf_raddra`/`rf_raddrb` are driven from the hold register at all times.
- Source availability in WAIT, evaluated per source s each cycle:
  - Source disabled or index 0 → operand = 0, available.
  - pend[s]==0 → operand = RF read data, available.
  - pend[s]==1 && wb_wen && wb_rd==s → operand = wb_data (bypass), available.
  - Otherwise stall.
  - A source is captured once and keeps its value; `got` is set.
- Writer-capacity stall: if rd_wen && rd!=0 && pend[rd]==2^CNT_W−1, the instruction stays in WAIT even if both operands are captured.
- WAIT→FULL at the edge where both sources are captured (or newly available) and there is no capacity stall.
- FULL:
  - Hold outputs stable while !out_ready.
  - On handshake, go to EMPTY, or to WAIT if a new instruction is accepted in the same cycle.
- Scoreboard pend[1..31], each CNT_W bits. pend[0] is constant 0.
  - Increment pend[out_rd] on the out handshake when out_rd_wen && out_rd!=0.
  - Decrement pend[wb_rd] when wb_wen && wb_rd!=0 && pend>0. A decrement at 0 is ignored and the counter stays 0.
  - Increment and decrement on the same register in the same cycle → unchanged.
  - A write-back to x0 is ignored entirely.
- Self-dependency (rs==rd) is checked against the count before this instruction's increment.
- Flush has priority over everything:
  - Next state EMPTY; `got` flags cleared.
  - An out handshake in the flush cycle is not counted, and execute must discard that instruction.
  - The scoreboard still applies write-back decrements.
- Reset mid-operation returns to EMPTY and zeroes all counters. Pending write-backs after reset are ignored because pend=0.

## Timing
- Reset values:
  - `out_valid`=0, `in_ready`=0 while rst_n low, 1 after release.
  - `out_src1`/`out_src2`=0, `out_rd`=0, `out_rd_wen`=0.
  - State EMPTY, all pend=0.
- Accept in cycle T → WAIT in T+1 → operands latched at end of T+1 with no hazard → `out_valid` in T+2.
- Throughput is one instruction per 2 cycles.
- Bypass capture: write-back in cycle W → `out_valid` in W+1.
- A dependent instruction accepted in the handshake cycle of its producer sees the incremented count in its first WAIT cycle.

## Test plan
- Reset, x1=5, x2=7, issue rs1=1, rs2=2 at T → out_valid at T+2, src1=5, src2=7, in_ready=0 during T+1..T+2.
- Issue writer rd=3 and hand it off; next instruction rs1=3 stalls in WAIT. wb_wen, wb_rd=3, wb_data=0xABCD → src1=0xABCD with out_valid the next cycle, pend[3]=0.
- Two writers to x4 outstanding (pend=2). A reader of x4 ignores the first write-back. The second write-back (0x22) releases it with src1=0x22.
- Three writers to x5 handed off with no write-back (pend=3). A fourth writer rd=5 stays in WAIT. One write-back to x5 → it proceeds next cycle, pend back to 3.
- Instruction rs1=0, rd=0, rd_wen=1 → src1=0, no pend change. wb_wen with wb_rd=0 → no effect.
- Flush during WAIT and during FULL with out_ready=1 → EMPTY next cycle, out_valid=0, pend unchanged. out_ready=0 for 5 cycles in FULL → outputs bit-stable.
